ppfifo_multichannel: RTL and testbench

- Next-generation push-pull FIFO: NUM_CHANNELS independent FIFO queues behind one shared put port and one shared get port.
- Width, depth and channel count are all parametrised; adds per-channel flush and full/empty status vectors.
- Sits between multi-stream producers and consumers in the Hamming datapath.
- Keeps the single-channel FIFO's registered req/ack handshake unchanged, so existing writer/reader drivers work with the channel select tied to 0.

---
 rtl/ppfifo_multichannel_if.sv | 41 ++++
 rtl/ppfifo_multichannel.sv | 163 ++++++++++++++++
 tb/tb_ppfifo_multichannel.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppfifo_multichannel_if.sv
// Shared put/get/flush bus of the multi-channel push-pull FIFO.
// The master modport belongs to the producer/consumer side.
// The slave modport belongs to the FIFO itself.
interface ppfifo_multichannel_if #(
    parameter int FIFO_WORD_SIZE = 8,
    parameter int NUM_CHANNELS   = 2
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                      put_req;
    logic [CW-1:0]             put_chan;
    logic [FIFO_WORD_SIZE-1:0] put_value;
    logic                      put_ack;

    logic                      get_req;
    logic [CW-1:0]             get_chan;
    logic [FIFO_WORD_SIZE-1:0] get_value;
    logic                      get_ack;

    logic                      flush_req;
    logic [CW-1:0]             flush_chan;

    logic [NUM_CHANNELS-1:0]   full_vec;
    logic [NUM_CHANNELS-1:0]   empty_vec;

    modport master (
        output put_req, put_chan, put_value,
        output get_req, get_chan,
        output flush_req, flush_chan,
        input  put_ack, get_value, get_ack,
        input  full_vec, empty_vec
    );

    modport slave (
        input  put_req, put_chan, put_value,
        input  get_req, get_chan,
        input  flush_req, flush_chan,
        output put_ack, get_value, get_ack,
        output full_vec, empty_vec
    );
endinterface

// File: rtl/ppfifo_multichannel.sv
// Multi-channel push-pull FIFO: NUM_CHANNELS independent queues behind one
// shared put port and one shared get port, using the registered req/ack
// handshake of the single-channel FIFO.
// Optional macro PPFIFO_STALL_COUNT_EN adds a saturating 16-bit counter of
// cycles in which a put was refused because its channel was full.
module ppfifo_multichannel #(
    parameter int FIFO_WORD_SIZE    = 8,
    parameter int FIFO_POINTER_BITS = 2,
    parameter int NUM_CHANNELS      = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    ppfifo_multichannel_if.slave bus
`ifdef PPFIFO_STALL_COUNT_EN
    ,
    output logic [15:0]          stall_count
`endif
);
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int SLOTS = 2 ** CW;
    localparam int DEPTH = 2 ** FIFO_POINTER_BITS;

    localparam logic [FIFO_POINTER_BITS:0]   FULL_COUNT = (FIFO_POINTER_BITS + 1)'(DEPTH);
    localparam logic [FIFO_POINTER_BITS:0]   CNT_ONE    = (FIFO_POINTER_BITS + 1)'(1);
    localparam logic [FIFO_POINTER_BITS-1:0] PTR_ONE    = FIFO_POINTER_BITS'(1);

    // Marks which select codes name a real channel; codes at or above
    // NUM_CHANNELS are never acked.
    function automatic logic [SLOTS-1:0] valid_mask_f();
        logic [SLOTS-1:0] m;
        m = '0;
        for (int i = 0; i < SLOTS; i++) begin
            m[i] = (i < NUM_CHANNELS);
        end
        return m;
    endfunction

    localparam logic [SLOTS-1:0] VALID_MASK = valid_mask_f();

    // Arrays are sized to every select code so indexing never goes out of
    // bounds; slots beyond NUM_CHANNELS stay at their reset value.
    logic [FIFO_WORD_SIZE-1:0]    mem    [SLOTS][DEPTH];
    logic [FIFO_POINTER_BITS-1:0] wr_ptr [SLOTS];
    logic [FIFO_POINTER_BITS-1:0] rd_ptr [SLOTS];
    logic [FIFO_POINTER_BITS:0]   count  [SLOTS];

    logic             put_full;
    logic             get_empty;
    logic             put_flushed;
    logic             get_flushed;
    logic             put_ok;
    logic             get_ok;
    logic [SLOTS-1:0] put_hit_vec;
    logic [SLOTS-1:0] get_hit_vec;
    logic [SLOTS-1:0] flush_vec;

    // Accept decisions from pre-edge counts; a flush of the same channel
    // wins, leaving the request pending for a later edge.
    always_comb begin
        put_full    = (count[bus.put_chan] == FULL_COUNT);
        get_empty   = (count[bus.get_chan] == '0);
        put_flushed = bus.flush_req && (bus.flush_chan == bus.put_chan);
        get_flushed = bus.flush_req && (bus.flush_chan == bus.get_chan);
        put_ok      = bus.put_req && !bus.put_ack && VALID_MASK[bus.put_chan]
                      && !put_full && !put_flushed;
        get_ok      = bus.get_req && !bus.get_ack && VALID_MASK[bus.get_chan]
                      && !get_empty && !get_flushed;
        put_hit_vec = '0;
        get_hit_vec = '0;
        flush_vec   = '0;
        if (put_ok) begin
            put_hit_vec[bus.put_chan] = 1'b1;
        end
        if (get_ok) begin
            get_hit_vec[bus.get_chan] = 1'b1;
        end
        if (bus.flush_req) begin
            flush_vec[bus.flush_chan] = 1'b1;
        end
    end

    // Per-channel pointer and occupancy bookkeeping, with flush taking priority.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int c = 0; c < SLOTS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (flush_vec[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    count[c]  <= '0;
                end else begin
                    if (put_hit_vec[c]) begin
                        wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
                    end
                    if (get_hit_vec[c]) begin
                        rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
                    end
                    case ({put_hit_vec[c], get_hit_vec[c]})
                        2'b10:   count[c] <= count[c] + CNT_ONE;
                        2'b01:   count[c] <= count[c] - CNT_ONE;
                        default: count[c] <= count[c];
                    endcase
                end
            end
        end
    end

    // Word storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clock) begin
        if (put_ok) begin
            mem[bus.put_chan][wr_ptr[bus.put_chan]] <= bus.put_value;
        end
    end

    // Registered ack pulses and read data; get_value holds between reads.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus.put_ack   <= 1'b0;
            bus.get_ack   <= 1'b0;
            bus.get_value <= '0;
        end else begin
            bus.put_ack <= put_ok;
            bus.get_ack <= get_ok;
            if (get_ok) begin
                bus.get_value <= mem[bus.get_chan][rd_ptr[bus.get_chan]];
            end
        end
    end

    // Status vectors decoded straight from the registered counts.
    always_comb begin
        bus.full_vec  = '0;
        bus.empty_vec = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            bus.full_vec[c]  = (count[c] == FULL_COUNT);
            bus.empty_vec[c] = (count[c] == '0);
        end
    end

`ifdef PPFIFO_STALL_COUNT_EN
    logic stall_hit;

    // A stall is a live put request refused only because its channel is full.
    always_comb begin
        stall_hit = bus.put_req && !bus.put_ack && VALID_MASK[bus.put_chan] && put_full;
    end

    // Saturating stall counter; flush leaves it untouched.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            stall_count <= '0;
        end else if (stall_hit && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ppfifo_multichannel.sv
// Self-checking bench for ppfifo_multichannel (8-bit words, depth 4, 2 channels).
// The reference model is one queue of words per channel.
`timescale 1ns/1ps
module tb_ppfifo_multichannel;
    localparam int W     = 8;
    localparam int PB    = 2;
    localparam int NCH   = 2;
    localparam int CW    = 1;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic clear;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    logic [W-1:0] q [NCH][$];

`ifdef PPFIFO_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    ppfifo_multichannel_if #(.FIFO_WORD_SIZE(W), .NUM_CHANNELS(NCH)) bus ();

    ppfifo_multichannel #(
        .FIFO_WORD_SIZE   (W),
        .FIFO_POINTER_BITS(PB),
        .NUM_CHANNELS     (NCH)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .bus        (bus)
`ifdef PPFIFO_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_idle();
        bus.put_req    = 1'b0;
        bus.get_req    = 1'b0;
        bus.flush_req  = 1'b0;
        bus.put_chan   = '0;
        bus.get_chan   = '0;
        bus.flush_chan = '0;
        bus.put_value  = '0;
    endtask

    task automatic check_status(input string tag);
        logic [NCH-1:0] ef;
        logic [NCH-1:0] ee;
        for (int c = 0; c < NCH; c++) begin
            ef[c] = (q[c].size() == DEPTH);
            ee[c] = (q[c].size() == 0);
        end
        check_output({tag, "_full_vec"}, 32'(bus.full_vec), 32'(ef));
        check_output({tag, "_empty_vec"}, 32'(bus.empty_vec), 32'(ee));
    endtask

    task automatic put_word(input int chan, input logic [W-1:0] value);
        bus.put_chan  = CW'(chan);
        bus.put_value = value;
        bus.put_req   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.put_ack) break;
        end
        check_output("put_ack", 32'(bus.put_ack), 32'd1);
        bus.put_req = 1'b0;
        q[chan].push_back(value);
    endtask

    task automatic get_word(input int chan);
        logic [W-1:0] expv;
        bus.get_chan = CW'(chan);
        bus.get_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.get_ack) break;
        end
        check_output("get_ack", 32'(bus.get_ack), 32'd1);
        expv = q[chan].pop_front();
        check_output("get_value", 32'(bus.get_value), 32'(expv));
        bus.get_req = 1'b0;
        tick();
        check_output("get_ack_pulse", 32'(bus.get_ack), 32'd0);
        check_output("get_value_hold", 32'(bus.get_value), 32'(expv));
    endtask

    initial begin
        logic [W-1:0] fill_words [4];
        int           last_ack;
        logic         pe, ge, fe, exp_put, exp_get;
        int           pc, gc, fc;
        logic [W-1:0] pv, gv;

        fill_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear = 1'b1;
        apply_idle();
        #12;
        $display("[TB] reset state");
        check_output("rst_put_ack", 32'(bus.put_ack), 32'd0);
        check_output("rst_get_ack", 32'(bus.get_ack), 32'd0);
        check_output("rst_get_value", 32'(bus.get_value), 32'd0);
        check_status("rst");
`ifdef PPFIFO_STALL_COUNT_EN
        check_output("rst_stall", 32'(stall_count), 32'd0);
`endif
        @(negedge clock);
        clear = 1'b0;

        $display("[TB] fill ch0 with held put_req");
        bus.put_chan = '0;
        bus.put_req  = 1'b1;
        last_ack     = 0;
        for (int i = 0; i < 4; i++) begin
            bus.put_value = fill_words[i];
            for (int k = 0; k < 10; k++) begin
                tick();
                if (bus.put_ack) break;
            end
            check_output("fill_put_ack", 32'(bus.put_ack), 32'd1);
            if (i > 0) check_output("fill_ack_spacing", 32'(cycle - last_ack), 32'd2);
            last_ack = cycle;
            q[0].push_back(fill_words[i]);
        end
        bus.put_value = 8'h55;
        check_status("full0");
        tick();
        check_output("full_put_ack_fall", 32'(bus.put_ack), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_output("full_put_refused", 32'(bus.put_ack), 32'd0);
`ifdef PPFIFO_STALL_COUNT_EN
            check_output("stall_count_inc", 32'(stall_count), 32'(i));
`endif
        end
        bus.put_req = 1'b0;
        tick();

        $display("[TB] drain ch0");
        for (int i = 0; i < 4; i++) get_word(0);
        check_status("drained");
        bus.get_chan = '0;
        bus.get_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("empty_get_refused", 32'(bus.get_ack), 32'd0);
        end
        bus.get_req = 1'b0;
        tick();

        $display("[TB] channel isolation");
        put_word(1, 8'hA0);
        put_word(0, 8'hB0);
        get_word(1);
        get_word(0);
        put_word(1, 8'hC1);
        tick();
        bus.put_chan  = 1'b0;
        bus.put_value = 8'hD0;
        bus.put_req   = 1'b1;
        bus.get_chan  = 1'b1;
        bus.get_req   = 1'b1;
        tick();
        check_output("conc_put_ack", 32'(bus.put_ack), 32'd1);
        check_output("conc_get_ack", 32'(bus.get_ack), 32'd1);
        check_output("conc_get_value", 32'(bus.get_value), 32'(q[1][0]));
        void'(q[1].pop_front());
        q[0].push_back(8'hD0);
        bus.put_req = 1'b0;
        bus.get_req = 1'b0;
        tick();
        check_status("conc");

        $display("[TB] full-channel simultaneous put and get");
        put_word(0, 8'h01);
        put_word(0, 8'h02);
        put_word(0, 8'h03);
        tick();
        check_status("full_again");
        bus.put_chan  = 1'b0;
        bus.put_value = 8'h99;
        bus.put_req   = 1'b1;
        bus.get_chan  = 1'b0;
        bus.get_req   = 1'b1;
        tick();
        check_output("sim_get_ack", 32'(bus.get_ack), 32'd1);
        check_output("sim_put_ack", 32'(bus.put_ack), 32'd0);
        check_output("sim_get_value", 32'(bus.get_value), 32'(q[0][0]));
        void'(q[0].pop_front());
        bus.get_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.put_ack) break;
        end
        check_output("sim_put_late_ack", 32'(bus.put_ack), 32'd1);
        q[0].push_back(8'h99);
        bus.put_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) get_word(0);

        $display("[TB] flush ch1");
        put_word(0, 8'h5A);
        put_word(0, 8'h5B);
        put_word(1, 8'h61);
        put_word(1, 8'h62);
        put_word(1, 8'h63);
        tick();
        check_status("pre_flush");
        bus.flush_chan = 1'b1;
        bus.flush_req  = 1'b1;
        bus.put_chan   = 1'b1;
        bus.put_value  = 8'h77;
        bus.put_req    = 1'b1;
        tick();
        q[1].delete();
        check_status("flush");
        check_output("flush_put_refused", 32'(bus.put_ack), 32'd0);
        bus.flush_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.put_ack) break;
        end
        check_output("flush_put_late_ack", 32'(bus.put_ack), 32'd1);
        q[1].push_back(8'h77);
        bus.put_req = 1'b0;
        tick();
        check_status("post_flush");
        get_word(1);
        check_status("post_flush_drain");
        get_word(0);
        get_word(0);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 200; it++) begin
            pe = ($urandom_range(0, 9) < 6);
            ge = ($urandom_range(0, 9) < 5);
            fe = ($urandom_range(0, 9) == 0);
            pc = int'($urandom_range(0, NCH - 1));
            gc = int'($urandom_range(0, NCH - 1));
            fc = int'($urandom_range(0, NCH - 1));
            pv = W'($urandom);
            if (fe && pc == fc) pe = 1'b0;
            if (fe && gc == fc) ge = 1'b0;
            exp_put = pe && (q[pc].size() < DEPTH);
            exp_get = ge && (q[gc].size() > 0);
            gv      = exp_get ? q[gc][0] : '0;
            bus.put_chan   = CW'(pc);
            bus.put_value  = pv;
            bus.put_req    = pe;
            bus.get_chan   = CW'(gc);
            bus.get_req    = ge;
            bus.flush_chan = CW'(fc);
            bus.flush_req  = fe;
            tick();
            check_output("rnd_put_ack", 32'(bus.put_ack), 32'(exp_put));
            check_output("rnd_get_ack", 32'(bus.get_ack), 32'(exp_get));
            if (exp_get) begin
                check_output("rnd_get_value", 32'(bus.get_value), 32'(gv));
                void'(q[gc].pop_front());
            end
            if (exp_put) q[pc].push_back(pv);
            if (fe) q[fc].delete();
            apply_idle();
            tick();
            check_output("rnd_ack_fall", 32'({bus.put_ack, bus.get_ack}), 32'd0);
            check_status("rnd");
        end

        $display("[TB] clear during traffic");
        while (q[0].size() > 0) get_word(0);
        while (q[1].size() > 0) get_word(1);
        put_word(0, 8'h3C);
        put_word(1, 8'h4D);
        get_word(0);
        bus.put_chan  = 1'b1;
        bus.put_value = 8'hEE;
        bus.put_req   = 1'b1;
        bus.get_chan  = 1'b1;
        bus.get_req   = 1'b1;
        tick();
        #2;
        clear = 1'b1;
        #1;
        q[0].delete();
        q[1].delete();
        check_output("clr_put_ack", 32'(bus.put_ack), 32'd0);
        check_output("clr_get_ack", 32'(bus.get_ack), 32'd0);
        check_output("clr_get_value", 32'(bus.get_value), 32'd0);
        check_status("clr");
        tick();
        tick();
        check_output("clr_held_acks", 32'({bus.put_ack, bus.get_ack}), 32'd0);
        apply_idle();
        @(negedge clock);
        clear = 1'b0;
        tick();
        check_status("post_clr");
`ifdef PPFIFO_STALL_COUNT_EN
        check_output("clr_stall", 32'(stall_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
